// File: rtl/sc_stream_counter_if.sv
// rtl/sc_stream_counter_if.sv - controller/converter handshake and bitstream bundle for sc_stream_counter
interface sc_stream_counter_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 start;
  logic                 abort;
  logic                 inBit;
  logic                 busy;
  logic [CNT_WIDTH-1:0] result;
  logic                 valid;

  modport master (
    output start, abort, inBit,
    input  busy, result, valid
  );

  modport slave (
    input  start, abort, inBit,
    output busy, result, valid
  );
endinterface

// File: rtl/sc_stream_counter.sv
// rtl/sc_stream_counter.sv - stochastic-to-binary ones counter over a 2^CNT_WIDTH window
// Define SCCNT_WARMUP_EN to discard the first WARMUP bits after start.
module sc_stream_counter #(
  parameter int CNT_WIDTH = 8,
  parameter int WARMUP    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  sc_stream_counter_if.slave  io
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
`ifdef SCCNT_WARMUP_EN
    , S_WARM = 2'd3
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH:0]   ones_q, ones_d;
  logic [CNT_WIDTH-1:0] win_q, win_d;
  logic [CNT_WIDTH-1:0] result_q, result_d;

`ifdef SCCNT_WARMUP_EN
  logic [7:0]           warm_q, warm_d;
`else
  logic [7:0]           unused_warmup;
  assign unused_warmup = 8'(WARMUP);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ones_q   <= '0;
      win_q    <= '0;
      result_q <= '0;
`ifdef SCCNT_WARMUP_EN
      warm_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ones_q   <= ones_d;
      win_q    <= win_d;
      result_q <= result_d;
`ifdef SCCNT_WARMUP_EN
      warm_q   <= warm_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    ones_d   = ones_q;
    win_d    = win_q;
    result_d = result_q;
`ifdef SCCNT_WARMUP_EN
    warm_d   = warm_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (io.start) begin
          ones_d  = '0;
          win_d   = '0;
`ifdef SCCNT_WARMUP_EN
          warm_d  = '0;
          state_d = S_WARM;
`else
          state_d = S_COUNT;
`endif
        end
      end
`ifdef SCCNT_WARMUP_EN
      S_WARM: begin
        warm_d = warm_q + 8'd1;
        if (warm_q == 8'(WARMUP - 1)) begin
          state_d = S_COUNT;
        end
      end
`endif
      S_COUNT: begin
        ones_d = ones_q + {{CNT_WIDTH{1'b0}}, io.inBit};
        win_d  = win_q + CNT_WIDTH'(1);
        if (win_q == '1) begin
          state_d = S_DONE;
          // The extra ones_d bit only sets for an all-ones window; clamp it.
          result_d = ones_d[CNT_WIDTH] ? '1 : ones_d[CNT_WIDTH-1:0];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort beats everything, including a window finishing on this edge.
    if (io.abort) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  assign io.busy   = (state_q != S_IDLE);
  assign io.valid  = (state_q == S_DONE);
  assign io.result = result_q;

endmodule

// File: tb/tb_sc_stream_counter.sv
// tb/tb_sc_stream_counter.sv - directed self-checking bench for sc_stream_counter (CNT_WIDTH=4)
module tb_sc_stream_counter;

`ifdef SCCNT_WARMUP_EN
  localparam int WU = 8;
`else
  localparam int WU = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  sc_stream_counter_if #(.CNT_WIDTH(4)) io ();

  sc_stream_counter #(.CNT_WIDTH(4), .WARMUP(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One full conversion starting in the current (IDLE) cycle; {valid,busy} checked every cycle.
  task automatic do_window(input logic [15:0] pat, input int exp_res, input logic start_in_done);
    int t0;
    t0 = cyc;
    io.start = 1'b1;
    check("idle_busy", io.busy, 0);
    tick();
    io.start = 1'b0;
    for (int i = 0; i < WU; i++) begin
      io.inBit = 1'b1;
      check("warm_vb", {io.valid, io.busy}, 2'b01);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      io.inBit = pat[i];
      check("count_vb", {io.valid, io.busy}, 2'b01);
      tick();
    end
    io.inBit = 1'b0;
    io.start = start_in_done;
    check("done_cycle", cyc, t0 + 17 + WU);
    check("done_vb", {io.valid, io.busy}, 2'b11);
    check("result", io.result, exp_res);
    tick();
    io.start = 1'b0;
    check("post_done_vb", {io.valid, io.busy}, 2'b00);
    check("result_hold", io.result, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    io.start = 1'b0;
    io.abort = 1'b0;
    io.inBit = 1'b0;

    // Reset held with inBit toggling
    for (int i = 0; i < 4; i++) begin
      io.inBit = ~io.inBit;
      tick();
      check("rst_outs", {io.valid, io.busy, io.result}, 0);
    end
    rst_n = 1'b1;
    io.inBit = 1'b0;
    cyc = 0;
    while (cyc < 5) begin
      check("idle_outs", {io.valid, io.busy, io.result}, 0);
      tick();
    end

    // Start at cycle 5, all zeros: valid at cycle 22 (+WU)
    do_window(16'h0000, 0, 1'b0);
    // All ones saturates
    do_window(16'hFFFF, 15, 1'b0);
    // Alternating, start in DONE ignored, then immediate restart
    do_window(16'h5555, 8, 1'b1);
    do_window(16'h5555, 8, 1'b0);

    // Abort on the 10th sampled bit
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    for (int i = 0; i < WU; i++) begin
      io.inBit = 1'b1;
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      io.inBit = 1'b1;
      if (i == 9) io.abort = 1'b1;
      check("abort_pre_busy", io.busy, 1);
      tick();
    end
    io.abort = 1'b0;
    io.inBit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("abort_vb", {io.valid, io.busy}, 2'b00);
      check("abort_result", io.result, 8);
      tick();
    end

    // Counters cleared on next start after abort
    do_window(16'h8001, 2, 1'b0);

    // start and abort together in IDLE
    io.start = 1'b1;
    io.abort = 1'b1;
    tick();
    io.start = 1'b0;
    io.abort = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("start_abort_vb", {io.valid, io.busy}, 2'b00);
      tick();
    end

    // Asynchronous reset mid-window
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      io.inBit = 1'b1;
      tick();
    end
    check("pre_rst_busy", io.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", {io.valid, io.busy, io.result}, 0);
    tick();
    rst_n = 1'b1;
    io.inBit = 1'b0;
    tick();
    check("post_rst_outs", {io.valid, io.busy, io.result}, 0);

    // Five ones in the window (warm-up bits are ones and must be discarded)
    do_window(16'h1249, 5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
